// File: rtl/quick_spi_slave_pkg.sv
// Shared definitions for the QuickSPI slave: FSM states and SPI mode encodings.
package quick_spi_slave_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    localparam bit CPOL_IDLE_LOW       = 1'b0;
    localparam bit CPHA_SAMPLE_LEADING = 1'b0;

endpackage

// File: rtl/quick_spi_slave_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, with single-clk rise/fall pulses
// derived from the synchronised level.
module quick_spi_slave_sync_edge #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign q_o    = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/quick_spi_slave.sv
// QuickSPI responder: oversamples the SPI pins in the clk domain, deserialises mosi into
// rx words and serialises words from a one-entry tx holding register onto miso.
module quick_spi_slave
    import quick_spi_slave_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter bit CPOL       = 1'b0,
    parameter bit CPHA       = 1'b0,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sclk,
    input  logic                  ss_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  tx_underrun
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    function automatic logic outBit(input logic [DATA_WIDTH-1:0] w);
        return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shiftOut(input logic [DATA_WIDTH-1:0] w);
        return MSB_FIRST ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
    endfunction

    logic sclkS, sclkRise, sclkFall;
    logic ssS, ssRise, ssFall;
    logic mosiS, mosiRise, mosiFall;
    logic unusedSyncBits;

    quick_spi_slave_sync_edge #(.RESET_VAL(CPOL)) uSclkSync (
        .clk(clk), .reset_n(reset_n), .d_i(sclk), .q_o(sclkS), .rise_o(sclkRise), .fall_o(sclkFall)
    );
    quick_spi_slave_sync_edge #(.RESET_VAL(1'b1)) uSsSync (
        .clk(clk), .reset_n(reset_n), .d_i(ss_n), .q_o(ssS), .rise_o(ssRise), .fall_o(ssFall)
    );
    quick_spi_slave_sync_edge #(.RESET_VAL(1'b0)) uMosiSync (
        .clk(clk), .reset_n(reset_n), .d_i(mosi), .q_o(mosiS), .rise_o(mosiRise), .fall_o(mosiFall)
    );

    assign unusedSyncBits = ^{sclkS, ssRise, mosiRise, mosiFall};

    state_e                state_q;
    logic [CW-1:0]         bitCount_q;
    logic [DATA_WIDTH-1:0] holdData_q;
    logic                  holdValid_q;
    logic [DATA_WIDTH-1:0] txShift_q;
    logic [DATA_WIDTH-1:0] rxShift_q;
    logic [DATA_WIDTH-1:0] rxData_q;
    logic                  rxValid_q;
    logic                  miso_q;
    logic                  busy_q;
    logic                  txUnderrun_q;
    logic                  underrunPend_q;

    logic                  leadEdge, trailEdge, sampleEdge, shiftEdge;
    logic                  accept, wordDone, loadNow;
    logic [DATA_WIDTH-1:0] loadWord, loadShift, rxNext;

    assign leadEdge   = (CPOL == CPOL_IDLE_LOW) ? sclkRise : sclkFall;
    assign trailEdge  = (CPOL == CPOL_IDLE_LOW) ? sclkFall : sclkRise;
    assign sampleEdge = (CPHA == CPHA_SAMPLE_LEADING) ? leadEdge : trailEdge;
    assign shiftEdge  = (CPHA == CPHA_SAMPLE_LEADING) ? trailEdge : leadEdge;

    assign accept    = tx_valid & ~holdValid_q;
    assign wordDone  = (state_q == ACTIVE) && !ssS && sampleEdge && (bitCount_q == LAST_BIT);
    assign loadNow   = ((state_q == IDLE) && ssFall) || wordDone;
    assign loadWord  = holdValid_q ? holdData_q : '0;
    assign loadShift = (CPHA == CPHA_SAMPLE_LEADING) ? shiftOut(loadWord) : loadWord;
    assign rxNext    = MSB_FIRST ? {rxShift_q[DATA_WIDTH-2:0], mosiS}
                                 : {mosiS, rxShift_q[DATA_WIDTH-1:1]};

    // An acceptance in the same clk as a load refills holding after the old value has moved out.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            holdData_q  <= '0;
            holdValid_q <= 1'b0;
        end else if (accept) begin
            holdData_q  <= tx_data;
            holdValid_q <= 1'b1;
        end else if (loadNow) begin
            holdValid_q <= 1'b0;
        end
    end

    // Underrun is reported when the loaded word's first bit is sampled, so the
    // speculative load after the last word of a frame stays silent.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            bitCount_q     <= '0;
            txShift_q      <= '0;
            rxShift_q      <= '0;
            rxData_q       <= '0;
            rxValid_q      <= 1'b0;
            miso_q         <= 1'b0;
            busy_q         <= 1'b0;
            txUnderrun_q   <= 1'b0;
            underrunPend_q <= 1'b0;
        end else begin
            rxValid_q    <= 1'b0;
            txUnderrun_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ssFall) begin
                        state_q        <= ACTIVE;
                        busy_q         <= 1'b1;
                        bitCount_q     <= '0;
                        underrunPend_q <= ~holdValid_q;
                        txShift_q      <= loadShift;
                        if (CPHA == CPHA_SAMPLE_LEADING) miso_q <= outBit(loadWord);
                    end
                end
                ACTIVE: begin
                    if (ssS) begin
                        state_q        <= IDLE;
                        busy_q         <= 1'b0;
                        bitCount_q     <= '0;
                        txShift_q      <= '0;
                        rxShift_q      <= '0;
                        miso_q         <= 1'b0;
                        underrunPend_q <= 1'b0;
                    end else if (sampleEdge) begin
                        rxShift_q <= rxNext;
                        if (bitCount_q == '0) begin
                            txUnderrun_q   <= underrunPend_q;
                            underrunPend_q <= 1'b0;
                        end
                        if (bitCount_q == LAST_BIT) begin
                            bitCount_q     <= '0;
                            rxData_q       <= rxNext;
                            rxValid_q      <= 1'b1;
                            underrunPend_q <= ~holdValid_q;
                            txShift_q      <= loadShift;
                            if (CPHA == CPHA_SAMPLE_LEADING) miso_q <= outBit(loadWord);
                        end else begin
                            bitCount_q <= bitCount_q + 1'b1;
                        end
                    end else if (shiftEdge) begin
                        if ((CPHA != CPHA_SAMPLE_LEADING) || (bitCount_q != '0)) begin
                            miso_q    <= outBit(txShift_q);
                            txShift_q <= shiftOut(txShift_q);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign miso        = miso_q;
    assign miso_oe     = busy_q;
    assign busy        = busy_q;
    assign tx_ready    = ~holdValid_q;
    assign rx_data     = rxData_q;
    assign rx_valid    = rxValid_q;
    assign tx_underrun = txUnderrun_q;

endmodule

// File: tb/tb_quick_spi_slave.sv
// Scoreboard bench for quick_spi_slave: one instance per SPI mode, shared bit-banged master.
`timescale 1ns/1ps
module tb_quick_spi_slave;

    localparam int HALF = 8;

    typedef struct {
        int         mode;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       mosi;
    logic [3:0] sclkA, ssA, misoA, misoOeA, txValidA, txReadyA, rxValidA, busyA, underA;
    logic [7:0] txDataA [4];
    logic [7:0] rxDataA [4];

    exp_t       sb [$];
    exp_t       e;
    int         underCnt [4] = '{0, 0, 0, 0};
    int         checks = 0;
    int         errors = 0;
    int         base;
    logic [7:0] r0, r1;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : gDut
        quick_spi_slave #(
            .DATA_WIDTH(8), .CPOL(g >= 2), .CPHA(g % 2 == 1), .MSB_FIRST(1'b1)
        ) dut (
            .clk(clk), .reset_n(reset_n), .sclk(sclkA[g]), .ss_n(ssA[g]), .mosi(mosi),
            .miso(misoA[g]), .miso_oe(misoOeA[g]), .tx_data(txDataA[g]), .tx_valid(txValidA[g]),
            .tx_ready(txReadyA[g]), .rx_data(rxDataA[g]), .rx_valid(rxValidA[g]),
            .busy(busyA[g]), .tx_underrun(underA[g])
        );
    end

    task automatic checkOutput(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, expv);
        end
    endtask

    task automatic checkReset(input int m, input string tag);
        checkOutput({tag, " miso"}, int'(misoA[m]), 0);
        checkOutput({tag, " miso_oe"}, int'(misoOeA[m]), 0);
        checkOutput({tag, " tx_ready"}, int'(txReadyA[m]), 1);
        checkOutput({tag, " rx_data"}, int'(rxDataA[m]), 0);
        checkOutput({tag, " rx_valid"}, int'(rxValidA[m]), 0);
        checkOutput({tag, " busy"}, int'(busyA[m]), 0);
        checkOutput({tag, " tx_underrun"}, int'(underA[m]), 0);
    endtask

    task automatic pushTx(input int m, input logic [7:0] d);
        bit done = 1'b0;
        @(negedge clk);
        txDataA[m]  = d;
        txValidA[m] = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            if (txReadyA[m]) done = 1'b1;
            else @(negedge clk);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL tx_accept m%0d: got tx_ready 0, required 1 within 300 clk", m);
        end else begin
            @(posedge clk);
        end
        @(negedge clk);
        txValidA[m] = 1'b0;
    endtask

    // Master: sends nWords words (first nBits bits each), returns what it read on miso.
    task automatic applyStimulus(input int m, input int nWords, input logic [7:0] w0,
                                 input logic [7:0] w1, input int nBits, input bit keepSs,
                                 output logic [7:0] rd0, output logic [7:0] rd1);
        logic       cpol, cpha;
        logic [7:0] w, r;
        cpol = (m >= 2);
        cpha = (m % 2 == 1);
        rd0  = 8'h00;
        rd1  = 8'h00;
        if (nBits == 8) begin
            sb.push_back('{mode: m, data: w0});
            if (nWords > 1) sb.push_back('{mode: m, data: w1});
        end
        ssA[m] = 1'b0;
        repeat (6) @(negedge clk);
        for (int k = 0; k < nWords; k++) begin
            w = (k == 0) ? w0 : w1;
            r = 8'h00;
            for (int b = 7; b > 7 - nBits; b--) begin
                if (!cpha) begin
                    mosi = w[b];
                    repeat (HALF) @(negedge clk);
                    r[b] = misoA[m];
                    sclkA[m] = ~cpol;
                    repeat (HALF) @(negedge clk);
                    sclkA[m] = cpol;
                end else begin
                    sclkA[m] = ~cpol;
                    mosi = w[b];
                    repeat (HALF) @(negedge clk);
                    r[b] = misoA[m];
                    sclkA[m] = cpol;
                    repeat (HALF) @(negedge clk);
                end
            end
            if (k == 0) rd0 = r;
            else rd1 = r;
        end
        if (!keepSs) begin
            repeat (HALF) @(negedge clk);
            ssA[m] = 1'b1;
            repeat (6) @(negedge clk);
        end
    endtask

    // Monitor: pops the scoreboard on every rx_valid and tallies underrun pulses.
    initial begin
        forever begin
            @(negedge clk);
            for (int m = 0; m < 4; m++) begin
                if (underA[m]) underCnt[m]++;
                if (rxValidA[m]) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL rx_unexpected m%0d: got %02h, required no rx_valid", m, rxDataA[m]);
                    end else begin
                        e = sb.pop_front();
                        checkOutput($sformatf("rx word m%0d", m), (m << 8) | int'(rxDataA[m]),
                                    (e.mode << 8) | int'(e.data));
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         modes [3] = '{3, 1, 2};
        logic [7:0] txw [3]   = '{8'h5A, 8'h96, 8'hF0};
        logic [7:0] rxw [3]   = '{8'hC3, 8'h69, 8'h0F};

        reset_n  = 1'b0;
        sclkA    = 4'b1100;
        ssA      = 4'hF;
        mosi     = 1'b0;
        txValidA = 4'h0;
        for (int m = 0; m < 4; m++) txDataA[m] = 8'h00;
        repeat (5) @(negedge clk);
        checkReset(0, "reset");
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] mode 0 single word");
        pushTx(0, 8'hA5);
        applyStimulus(0, 1, 8'h3C, 8'h00, 8, 1'b0, r0, r1);
        checkOutput("t1 master read", int'(r0), 'hA5);
        checkOutput("t1 underruns", underCnt[0], 0);

        $display("[TB] modes 3, 1, 2");
        for (int i = 0; i < 3; i++) begin
            pushTx(modes[i], txw[i]);
            applyStimulus(modes[i], 1, rxw[i], 8'h00, 8, 1'b0, r0, r1);
            checkOutput($sformatf("t2 master read m%0d", modes[i]), int'(r0), int'(txw[i]));
        end

        $display("[TB] back-to-back words");
        base = underCnt[0];
        pushTx(0, 8'h11);
        fork
            applyStimulus(0, 2, 8'h81, 8'h42, 8, 1'b0, r0, r1);
            begin
                repeat (2) @(negedge clk);
                pushTx(0, 8'h22);
            end
        join
        checkOutput("t3 master read 0", int'(r0), 'h11);
        checkOutput("t3 master read 1", int'(r1), 'h22);
        checkOutput("t3 underruns", underCnt[0] - base, 0);

        $display("[TB] aborted word");
        pushTx(0, 8'h77);
        applyStimulus(0, 1, 8'hC5, 8'h00, 5, 1'b0, r0, r1);
        checkOutput("t4 busy", int'(busyA[0]), 0);
        checkOutput("t4 miso_oe", int'(misoOeA[0]), 0);
        pushTx(0, 8'h99);
        applyStimulus(0, 1, 8'h66, 8'h00, 8, 1'b0, r0, r1);
        checkOutput("t4 master read", int'(r0), 'h99);

        $display("[TB] underrun");
        base = underCnt[0];
        applyStimulus(0, 1, 8'hB4, 8'h00, 8, 1'b0, r0, r1);
        checkOutput("t5 master read", int'(r0), 'h00);
        checkOutput("t5 underruns", underCnt[0] - base, 1);
        checkOutput("t5 tx_ready", int'(txReadyA[0]), 1);

        $display("[TB] reset mid-word");
        pushTx(0, 8'h3A);
        fork
            applyStimulus(0, 1, 8'hD2, 8'h00, 3, 1'b1, r0, r1);
            begin
                repeat (20) @(negedge clk);
                pushTx(0, 8'h4B);
            end
        join
        reset_n = 1'b0;
        @(negedge clk);
        checkReset(0, "t6");
        ssA[0] = 1'b1;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        pushTx(0, 8'hE7);
        applyStimulus(0, 1, 8'h18, 8'h00, 8, 1'b0, r0, r1);
        checkOutput("t6 master read", int'(r0), 'hE7);

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        checkOutput("scoreboard drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
